mem_bus_arbiter: RTL

Shares the single external 64-bit memory bus between instruction fetch (read-only) and the mem stage data port (read/write with byte mask).
- One outstanding transaction at a time; data port has fixed priority, with a starvation guard for fetch.
- Per-requester ready pulses act as the pipeline stall release: fetch and mem stage stall while their ready is low and their request is high.
- Sits between the fetch/mem pipeline stages and the memory bus.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_arb_select.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// Imported by the arbiter top and its grant-select sub-module.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ACK  = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam logic [7:0] BUS_MASK_NONE = 8'h00;
  localparam logic [7:0] BUS_MASK_ALL  = 8'hFF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External 64-bit memory bus: request channel out, accept/response channel in.
// The master modport is the arbiter side, the slave modport is the memory side.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 64
) ();

  logic                  bus_valid_out;
  logic                  bus_write_out;
  logic [ADDR_WIDTH-1:0] bus_address_out;
  logic [63:0]           bus_write_value_out;
  logic [7:0]            bus_write_mask_out;
  logic                  bus_ready_in;
  logic                  bus_rvalid_in;
  logic [63:0]           bus_read_value_in;

  modport master (
    output bus_valid_out,
    output bus_write_out,
    output bus_address_out,
    output bus_write_value_out,
    output bus_write_mask_out,
    input  bus_ready_in,
    input  bus_rvalid_in,
    input  bus_read_value_in
  );

  modport slave (
    input  bus_valid_out,
    input  bus_write_out,
    input  bus_address_out,
    input  bus_write_value_out,
    input  bus_write_mask_out,
    output bus_ready_in,
    output bus_rvalid_in,
    output bus_read_value_in
  );

endinterface

// File: rtl/mem_arb_select.sv
// Grant decision between fetch and data requesters, plus the fetch starvation counter.
// Data has fixed priority until it has won INSTR_STARVE_LIMIT grants over a waiting fetch.
module mem_arb_select
  import mem_bus_pkg::*;
#(
  parameter int unsigned INSTR_STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   instr_req_i,
  input  logic   data_req_i,
  input  logic   cnt_en_i,
  output owner_e grant_owner_o,
  output logic   grant_valid_o
);

  localparam logic [3:0] STARVE_LIMIT = 4'(INSTR_STARVE_LIMIT);

  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;
  logic       starve_hit;

  assign starve_hit = (starve_cnt_q == STARVE_LIMIT);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid_o = instr_req_i | data_req_i;
    grant_owner_o = OWNER_DATA;
    if (!data_req_i || (starve_hit && instr_req_i)) begin
      grant_owner_o = OWNER_INSTR;
    end
  end

  // Count only while fetch is actually waiting; any idle moment without a fetch resets the debt.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (cnt_en_i) begin
      if (!instr_req_i || grant_owner_o == OWNER_INSTR) begin
        starve_cnt_d = '0;
      end else if (data_req_i && !starve_hit) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external 64-bit memory bus between instruction fetch and the mem-stage data port.
// One transaction in flight; IDLE -> REQ -> RESP -> ACK, with all bus outputs from grant-time registers.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned INSTR_STARVE_LIMIT = 4,
  parameter int unsigned ADDR_WIDTH         = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  instr_read_in,
  input  logic [ADDR_WIDTH-1:0] instr_address_in,
  output logic                  instr_ready_out,
  output logic [63:0]           instr_read_value_out,

  input  logic                  data_read_in,
  input  logic                  data_write_in,
  input  logic [ADDR_WIDTH-1:0] data_address_in,
  input  logic [63:0]           data_write_value_in,
  input  logic [7:0]            data_write_mask_in,
  output logic                  data_ready_out,
  output logic [63:0]           data_read_value_out,

  mem_bus_arbiter_if.master     bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_RESP = RESP;
  localparam logic [1:0] S_ACK  = ACK;

  logic [1:0]            state_q,    state_d;
  owner_e                owner_q,    owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic                  write_q,    write_d;
  logic [63:0]           wdata_q,    wdata_d;
  logic [7:0]            mask_q,     mask_d;
  logic [63:0]           instr_rv_q, instr_rv_d;
  logic [63:0]           data_rv_q,  data_rv_d;

  logic   data_req;
  logic   grant_valid;
  owner_e grant_owner;

  assign data_req = data_read_in | data_write_in;

  mem_arb_select #(
    .INSTR_STARVE_LIMIT (INSTR_STARVE_LIMIT)
  ) u_select (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_req_i   (instr_read_in),
    .data_req_i    (data_req),
    .cnt_en_i      (state_q == S_IDLE),
    .grant_owner_o (grant_owner),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    instr_rv_d = instr_rv_q;
    data_rv_d  = data_rv_q;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d = S_REQ;
          owner_d = grant_owner;
          if (grant_owner == OWNER_DATA) begin
            // A simultaneous read+write is issued as the write.
            addr_d  = data_address_in;
            write_d = data_write_in;
            wdata_d = data_write_in ? data_write_value_in : 64'd0;
            mask_d  = data_write_in ? data_write_mask_in  : BUS_MASK_NONE;
          end else begin
            addr_d  = instr_address_in;
            write_d = 1'b0;
            wdata_d = 64'd0;
            mask_d  = BUS_MASK_NONE;
          end
        end
      end

      S_REQ: begin
        if (bus.bus_ready_in) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.bus_rvalid_in) begin
          state_d = S_ACK;
          if (!write_q) begin
            if (owner_q == OWNER_DATA) begin
              data_rv_d = bus.bus_read_value_in;
            end else begin
              instr_rv_d = bus.bus_read_value_in;
            end
          end
        end
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read value registers are reset too: outputs must read zero after reset, not stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= OWNER_INSTR;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= 64'd0;
      mask_q     <= BUS_MASK_NONE;
      instr_rv_q <= 64'd0;
      data_rv_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      instr_rv_q <= instr_rv_d;
      data_rv_q  <= data_rv_d;
    end
  end

  assign bus.bus_valid_out       = (state_q == S_REQ);
  assign bus.bus_write_out       = write_q;
  assign bus.bus_address_out     = addr_q;
  assign bus.bus_write_value_out = wdata_q;
  assign bus.bus_write_mask_out  = mask_q;

  assign instr_ready_out      = (state_q == S_ACK) && (owner_q == OWNER_INSTR);
  assign data_ready_out       = (state_q == S_ACK) && (owner_q == OWNER_DATA);
  assign instr_read_value_out = instr_rv_q;
  assign data_read_value_out  = data_rv_q;

endmodule
